// File: rtl/stream_arb2.sv
// stream_arb2 -- two-input round-robin packet arbiter with a one-entry
// registered output stage.
//
// The arbiter picks source A or B, holds that grant until the packet's last
// beat has been accepted, then hands priority to the other source. Accepted
// beats are registered and appear on out_* one cycle later.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_valid/a_data/a_last       source A beat          a_ready  A accepted
//   b_valid/b_data/b_last       source B beat          b_ready  B accepted
//   sel                         current selection (0 = A, 1 = B)
//   out_valid/out_data/out_last registered beat
//   out_src                     source of the registered beat (0 = A, 1 = B)
//   out_ready                   consumer accepts the registered beat
module stream_arb2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_A = 2'd1;
  localparam logic [1:0] ST_LOCK_B = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;   // source granted most recently
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;

  logic             load_en;
  logic             sel_c;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  // Stage can take a beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Selection: a lock pins the grant; in IDLE a lone valid source wins,
  // otherwise the source that did not win last time is offered.
  always_comb begin
    sel_c = ~prio_q;
    if (rst) begin
      sel_c = 1'b0;
    end else begin
      case (state_q)
        ST_LOCK_A: sel_c = 1'b0;
        ST_LOCK_B: sel_c = 1'b1;
        default: begin
          if (a_valid && !b_valid)      sel_c = 1'b0;
          else if (b_valid && !a_valid) sel_c = 1'b1;
          else                          sel_c = ~prio_q;
        end
      endcase
    end
  end

  assign sel     = sel_c;
  assign a_ready = !rst && load_en && !sel_c;
  assign b_ready = !rst && load_en && sel_c;

  // Same sel ? B : A convention as the downstream mux.
  assign xfer      = sel_c ? (b_valid && b_ready) : (a_valid && a_ready);
  assign beat_data = sel_c ? b_data : a_data;
  assign beat_last = sel_c ? b_last : a_last;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (xfer) begin
      if (beat_last) begin
        state_d = ST_IDLE;
        prio_d  = sel_c;
      end else begin
        state_d = sel_c ? ST_LOCK_B : ST_LOCK_A;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_last_d  = beat_last;
      out_src_d   = sel_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;   // drained, payload fields keep their value
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b1;  // B counts as last winner so A goes first
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule
